pc_sequencer: RTL

//  Parametrised program counter for the 16-bit custom core: next-generation PC with stall,

---
 rtl/pc_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program counter with stall, jump, PC-relative branch and call/return.
// Define PC_RAS_EN to build the hardware return-address stack; otherwise call acts as jump and ret as increment.
module pc_sequencer #(
  parameter int              ADDR_W     = 8,
  parameter int              OFF_W      = 6,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              branch,
  input  logic [OFF_W-1:0]  branch_off,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_RET,
    OP_CALL,
    OP_JUMP,
    OP_BRANCH,
    OP_INC
  } op_t;

  op_t               op;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] pc_next;

  assign pc_inc    = instr_addr + ADDR_W'(1);
  // Size cast of a signed operand sign-extends the offset before the modular add.
  assign br_target = instr_addr + ADDR_W'($signed(branch_off));

  always_comb begin
    op = OP_INC;
    if (stall)       op = OP_HOLD;
    else if (ret)    op = OP_RET;
    else if (call)   op = OP_CALL;
    else if (jump)   op = OP_JUMP;
    else if (branch) op = OP_BRANCH;
  end

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count;
  logic              err_q;

  // wr_ptr is the next push slot; when full it already points at the oldest entry.
  assign top_ptr   = wr_ptr - PTR_W'(1);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CNT_W'(RAS_DEPTH));
  assign ras_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      case (op)
        OP_RET: begin
          if (ras_empty) begin
            err_q <= 1'b1;
          end else begin
            count  <= count - CNT_W'(1);
            wr_ptr <= top_ptr;
          end
        end
        OP_CALL: begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (ras_full) err_q <= 1'b1;
          else          count <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && op == OP_CALL) ras_mem[wr_ptr] <= pc_inc;
  end

  always_comb begin
    pc_next = pc_inc;
    case (op)
      OP_HOLD:   pc_next = instr_addr;
      OP_RET:    pc_next = ras_empty ? pc_inc : ras_mem[top_ptr];
      OP_CALL:   pc_next = jump_addr;
      OP_JUMP:   pc_next = jump_addr;
      OP_BRANCH: pc_next = br_target;
      default:   pc_next = pc_inc;
    endcase
  end
`else
  assign ras_empty = 1'b1;
  assign ras_full  = (RAS_DEPTH == 0);
  assign ras_err   = 1'b0;

  always_comb begin
    pc_next = pc_inc;
    case (op)
      OP_HOLD:   pc_next = instr_addr;
      OP_RET:    pc_next = pc_inc;
      OP_CALL:   pc_next = jump_addr;
      OP_JUMP:   pc_next = jump_addr;
      OP_BRANCH: pc_next = br_target;
      default:   pc_next = pc_inc;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) instr_addr <= RESET_ADDR;
    else     instr_addr <= pc_next;
  end

endmodule
